// File: rtl/alu_div_arbiter.sv
// Round-robin arbiter sharing one pipelined divider between NUM_REQ
// requesters. Illegal opcodes are answered locally with a zero result.
module alu_div_arbiter #(
    parameter int                      NUM_REQ      = 4,
    parameter int                      DATA_WIDTH   = 32,
    parameter int                      OPCODE_WIDTH = 6,
    parameter logic [OPCODE_WIDTH-1:0] ALU_OP_DIVN  = OPCODE_WIDTH'(17),
    parameter logic [OPCODE_WIDTH-1:0] ALU_OP_DIVZ  = OPCODE_WIDTH'(18)
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic [NUM_REQ-1:0]              req_operator_valid,
    input  logic [NUM_REQ-1:0]              req_left_valid,
    input  logic [NUM_REQ-1:0]              req_right_valid,
    input  logic [NUM_REQ*OPCODE_WIDTH-1:0] req_operator_data,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_left_data,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_right_data,
    output logic [NUM_REQ-1:0]              req_ack,
    output logic [NUM_REQ-1:0]              rsp_result_valid,
    output logic [NUM_REQ-1:0]              rsp_overflow_valid,
    output logic [DATA_WIDTH-1:0]           rsp_result_data,
    output logic [DATA_WIDTH-1:0]           rsp_overflow_data,
    input  logic [NUM_REQ-1:0]              rsp_result_ack,
    input  logic [NUM_REQ-1:0]              rsp_overflow_ack,
    output logic                            div_operator_valid,
    output logic                            div_left_valid,
    output logic                            div_right_valid,
    output logic [OPCODE_WIDTH-1:0]         div_operator_data,
    output logic [DATA_WIDTH-1:0]           div_left_data,
    output logic [DATA_WIDTH-1:0]           div_right_data,
    input  logic                            div_operator_ack,
    input  logic                            div_left_ack,
    input  logic                            div_right_ack,
    input  logic                            div_result_valid,
    input  logic                            div_overflow_valid,
    input  logic [DATA_WIDTH-1:0]           div_result_data,
    input  logic [DATA_WIDTH-1:0]           div_overflow_data,
    output logic                            div_result_ack,
    output logic                            div_overflow_ack,
    output logic                            busy,
    output logic [15:0]                     illegal_count
);

    localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_LOCAL} state_e;

    state_e            state_q, state_d;
    logic [IDXW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDXW-1:0]   grant_q, grant_d;
    logic              res_done_q, res_done_d;
    logic              ovf_done_q, ovf_done_d;
    logic              lack_q, lack_d;      // LOCAL: request already acked
    logic [15:0]       ill_q, ill_d;

    logic [OPCODE_WIDTH-1:0] op_arr    [NUM_REQ];
    logic [DATA_WIDTH-1:0]   left_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0]   right_arr [NUM_REQ];
    logic [NUM_REQ-1:0]      elig;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign op_arr[g]    = req_operator_data[g*OPCODE_WIDTH +: OPCODE_WIDTH];
        assign left_arr[g]  = req_left_data[g*DATA_WIDTH +: DATA_WIDTH];
        assign right_arr[g] = req_right_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    assign elig = req_operator_valid & req_left_valid & req_right_valid;

    logic            win_found;
    logic [IDXW-1:0] win_idx;
    logic            win_legal;
    logic [IDXW-1:0] nxt_ptr;

    // Round-robin search: first eligible requester at or after rr_ptr
    always_comb begin
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!win_found && elig[IDXW'(idx)]) begin
                win_found = 1'b1;
                win_idx   = IDXW'(idx);
            end
        end
    end

    assign win_legal = (op_arr[win_idx] == ALU_OP_DIVN) || (op_arr[win_idx] == ALU_OP_DIVZ);
    assign nxt_ptr   = IDXW'((int'(grant_q) + 1) % NUM_REQ);

    // Response phase: WAIT forwards divider output, LOCAL answers with zeros
    logic rsp_phase, res_vld, ovf_vld, res_xfer, ovf_xfer, issue_xfer;
    assign rsp_phase  = (state_q == S_WAIT) || ((state_q == S_LOCAL) && lack_q);
    assign res_vld    = rsp_phase && !res_done_q && ((state_q == S_LOCAL) || div_result_valid);
    assign ovf_vld    = rsp_phase && !ovf_done_q && ((state_q == S_LOCAL) || div_overflow_valid);
    assign res_xfer   = res_vld && rsp_result_ack[grant_q];
    assign ovf_xfer   = ovf_vld && rsp_overflow_ack[grant_q];
    assign issue_xfer = (state_q == S_ISSUE) && div_operator_ack && div_left_ack && div_right_ack;

    // State register and datapath registers; reset overrides everything
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            res_done_q <= 1'b0;
            ovf_done_q <= 1'b0;
            lack_q     <= 1'b0;
            ill_q      <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            res_done_q <= res_done_d;
            ovf_done_q <= ovf_done_d;
            lack_q     <= lack_d;
            ill_q      <= ill_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        res_done_d = res_done_q;
        ovf_done_d = ovf_done_q;
        lack_d     = lack_q;
        ill_d      = ill_q;
        case (state_q)
            S_IDLE: begin
                res_done_d = 1'b0;
                ovf_done_d = 1'b0;
                lack_d     = 1'b0;
                if (win_found) begin
                    grant_d = win_idx;
                    state_d = win_legal ? S_ISSUE : S_LOCAL;
                end
            end
            S_ISSUE: begin
                if (issue_xfer) begin
                    rr_ptr_d   = nxt_ptr;
                    res_done_d = 1'b0;
                    ovf_done_d = 1'b0;
                    state_d    = S_WAIT;
                end
            end
            S_LOCAL, S_WAIT: begin
                if ((state_q == S_LOCAL) && !lack_q) begin
                    // one-cycle request ack, then fall into the response phase
                    lack_d   = 1'b1;
                    rr_ptr_d = nxt_ptr;
                    if (ill_q != 16'hFFFF) ill_d = ill_q + 16'd1;
                end else begin
                    if (res_xfer) res_done_d = 1'b1;
                    if (ovf_xfer) ovf_done_d = 1'b1;
                    if ((res_done_q || res_xfer) && (ovf_done_q || ovf_xfer))
                        state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode; divider outputs are acked and dropped outside WAIT
    always_comb begin
        req_ack            = '0;
        rsp_result_valid   = '0;
        rsp_overflow_valid = '0;
        rsp_result_data    = '0;
        rsp_overflow_data  = '0;
        div_operator_valid = 1'b0;
        div_left_valid     = 1'b0;
        div_right_valid    = 1'b0;
        div_operator_data  = '0;
        div_left_data      = '0;
        div_right_data     = '0;
        div_result_ack     = 1'b1;
        div_overflow_ack   = 1'b1;
        case (state_q)
            S_ISSUE: begin
                div_operator_valid = 1'b1;
                div_left_valid     = 1'b1;
                div_right_valid    = 1'b1;
                div_operator_data  = op_arr[grant_q];
                div_left_data      = left_arr[grant_q];
                div_right_data     = right_arr[grant_q];
                req_ack[grant_q]   = issue_xfer;
            end
            S_WAIT: begin
                rsp_result_valid[grant_q]   = res_vld;
                rsp_overflow_valid[grant_q] = ovf_vld;
                rsp_result_data             = div_result_data;
                rsp_overflow_data           = div_overflow_data;
                div_result_ack              = rsp_result_ack[grant_q] && !res_done_q;
                div_overflow_ack            = rsp_overflow_ack[grant_q] && !ovf_done_q;
            end
            S_LOCAL: begin
                req_ack[grant_q]            = !lack_q;
                rsp_result_valid[grant_q]   = res_vld;
                rsp_overflow_valid[grant_q] = ovf_vld;
            end
            default: ;
        endcase
        // Nothing may commit while reset is asserted
        if (!reset_n) begin
            req_ack            = '0;
            rsp_result_valid   = '0;
            rsp_overflow_valid = '0;
            rsp_result_data    = '0;
            rsp_overflow_data  = '0;
            div_operator_valid = 1'b0;
            div_left_valid     = 1'b0;
            div_right_valid    = 1'b0;
            div_result_ack     = 1'b1;
            div_overflow_ack   = 1'b1;
        end
    end

    assign busy          = (state_q != S_IDLE);
    assign illegal_count = ill_q;

endmodule

// File: doc/alu_div_arbiter.md
Name: alu_div_arbiter

Overview:
- Shares one alu_pipelined_div instance between NUM_REQ requesters.
- Performs round-robin selection among complete requests and forwards the winner's operator/left/right to the divider.
- Tags the transaction with the winner's index, routes result/overflow back to that requester only, and handles illegal opcodes locally.
- Sits between the ALU issue stage and the shared divider.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_WIDTH, 32, operand/result width; must match divider.
- OPCODE_WIDTH, 6, operator width.
- ALU_OP_DIVN, 6'd17, legal divide opcode.
- ALU_OP_DIVZ, 6'd18, legal divide opcode.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  synchronous active-low reset
- req_operator_valid / req_left_valid / req_right_valid  in  NUM_REQ each  per-requester valids
- req_operator_data  in  NUM_REQ*OPCODE_WIDTH  packed, requester i at [i*OPCODE_WIDTH +: OPCODE_WIDTH]
- req_left_data / req_right_data  in  NUM_REQ*DATA_WIDTH  packed likewise
- req_ack  out  NUM_REQ  common ack for all three operand channels of requester i
- rsp_result_valid / rsp_overflow_valid  out  NUM_REQ  one-hot to owner
- rsp_result_data / rsp_overflow_data  out  DATA_WIDTH  shared bus, qualified by valids
- rsp_result_ack / rsp_overflow_ack  in  NUM_REQ
- div_operator_valid / div_left_valid / div_right_valid  out  1
- div_operator_data  out  OPCODE_WIDTH
- div_left_data / div_right_data  out  DATA_WIDTH
- div_operator_ack / div_left_ack / div_right_ack  in  1
- div_result_valid / div_overflow_valid  in  1
- div_result_data / div_overflow_data  in  DATA_WIDTH
- div_result_ack / div_overflow_ack  out  1
- busy  out  1  high when state != IDLE
- illegal_count  out  16  saturating count of rejected opcodes

Behaviour:
- Handshake: transfer occurs when valid && ack in the same cycle. Requesters hold valid and data stable until acked. Acks are combinational.
- Eligibility: requester i is eligible when all three of its valids are high.
- States: IDLE, ISSUE, WAIT, LOCAL.
- IDLE:
  - Round-robin search starts at rr_ptr. First eligible index is registered as grant.
  - Next state is LOCAL if grant's opcode is neither DIVN nor DIVZ, else ISSUE.
  - No request side acks are driven in IDLE.
- ISSUE:
  - All three div_*_valid = 1, data muxed from grant.
  - req_ack[grant] = div_operator_ack && div_left_ack && div_right_ack.
  - On that ack: rr_ptr <= (grant+1) mod NUM_REQ; go to WAIT; clear res_done/ovf_done.
  - Issue latency: request seen in cycle N, earliest divider accept in cycle N+1.
- WAIT:
  - rsp_result_valid[grant] = div_result_valid && !res_done; rsp_result_data = div_result_data; div_result_ack = rsp_result_ack[grant].
  - Overflow channel is identical, using ovf_done.
  - Result and overflow are acked independently, in any order or the same cycle.
  - Next state is IDLE once both have transferred. A same-cycle final transfer counts.
  - No added latency on the return path.
- LOCAL:
  - req_ack[grant] = 1 for one cycle, with no divider access.
  - Then returns result = 0, overflow = 0 to grant via the rsp channels with the WAIT done-flag rules.
  - illegal_count increments once, saturating at 16'hFFFF.
  - rr_ptr advances as in ISSUE.
- Stray divider output: in IDLE, ISSUE or LOCAL, a high div_result_valid/div_overflow_valid is acked and discarded and never appears on rsp_*. The divider has no reset, so this covers reset mid-division.
- Non-owners: rsp_*_valid of non-owners and req_ack of non-grant requesters are always 0.
- Reset (reset_n low at clock edge): state IDLE, rr_ptr 0, grant 0, done flags 0, illegal_count 0.
  - Outputs: div_*_valid 0, req_ack 0, rsp_*_valid 0, busy 0, rsp data 0.
  - Reset wins over any simultaneous event.
- Division by zero is forwarded unchanged; the divider's output (result all-ones, overflow = left) is passed back verbatim.

Test Plan:
- Requester 2 alone sends DIVN, 100/7 -> req_ack[2] once; rsp_result_valid[2] with 14, rsp_overflow_valid[2] with 2; valids of 0,1,3 stay 0.
- All 4 requesters hold valid requests continuously from reset -> grants in order 0,1,2,3,0; each gets its own quotient (operands i*10+50 / i+3).
- Requester 1 sends opcode 6'd5, left 9, right 3 -> divider valids never rise; result 0, overflow 0 to requester 1; illegal_count = 1.
- Owner acks overflow 3 cycles before result -> each channel delivered exactly once; busy drops the cycle after the result ack; next grant follows.
- Assert reset_n low for 1 cycle mid-division, then requester 0 sends 50/5 -> stray divider outputs acked and dropped; requester 0 receives 10 / 0 only.
- Request 7/0 -> result 32'hFFFFFFFF, overflow 7.
